// File: rtl/data_mem_pkg.sv
// Shared definitions for the data-memory responder: FSM encoding and
// default geometry of the memory.
package data_mem_pkg;

  localparam int DEF_MEM_WIDTH = 12;
  localparam int DEF_MEM_ADDR  = 12;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DUMP = 2'd3
  } state_t;

endpackage

// File: rtl/dm_ram.sv
// Storage for the responder: one write port and two synchronous read
// ports. Read-during-write on the same address returns the old word.
// Reset clears only the read registers, never the array.
module dm_ram #(
  parameter int W = 12,
  parameter int A = 12
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         we_i,
  input  logic [A-1:0] waddr_i,
  input  logic [W-1:0] wdata_i,
  input  logic [A-1:0] a_addr_i,
  output logic [W-1:0] a_rdata_o,
  input  logic         b_en_i,
  input  logic [A-1:0] b_addr_i,
  output logic [W-1:0] b_rdata_o
);

  logic [W-1:0] mem [2**A];

  // Single write port; the array itself has no reset.
  always_ff @(posedge clock) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end

  // Core read port: reads every cycle, one-cycle latency.
  always_ff @(posedge clock) begin
    if (reset) a_rdata_o <= '0;
    else       a_rdata_o <= mem[a_addr_i];
  end

  // Dump read port: only loads when enabled so the word holds during stalls.
  always_ff @(posedge clock) begin
    if (reset)       b_rdata_o <= '0;
    else if (b_en_i) b_rdata_o <= mem[b_addr_i];
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: host preloads a burst (LOAD), core runs against
// the memory (RUN), then a result region is streamed back to the host (DUMP).
//
// Handshakes: a word transfers on a rising edge where valid and ready are
// both high. The producer keeps valid and data stable until that edge; the
// consumer may drive ready freely. host_wr_ready is high only in LOAD;
// host_rd_valid is a register that never depends on host_rd_ready.
module data_mem_responder
  import data_mem_pkg::*;
#(
  parameter int MEM_WIDTH = DEF_MEM_WIDTH,
  parameter int MEM_ADDR  = DEF_MEM_ADDR
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [MEM_ADDR-1:0]  core_addr,
  input  logic [MEM_WIDTH-1:0] core_wdata,
  input  logic                 core_we,
  output logic [MEM_WIDTH-1:0] core_rdata,
  input  logic                 start,
  input  logic                 done,
  input  logic [MEM_ADDR-1:0]  load_base,
  input  logic                 host_wr_valid,
  input  logic [MEM_WIDTH-1:0] host_wr_data,
  input  logic                 host_wr_last,
  output logic                 host_wr_ready,
  input  logic [MEM_ADDR-1:0]  dump_base,
  input  logic [MEM_ADDR:0]    dump_len,
  output logic                 host_rd_valid,
  output logic [MEM_WIDTH-1:0] host_rd_data,
  input  logic                 host_rd_ready,
  output logic                 dump_done,
  output logic                 busy,
  output logic [1:0]           state_dbg
);

  state_t                state_q, state_d;
  logic [MEM_ADDR-1:0]   ptr_q, ptr_d;
  logic [MEM_ADDR:0]     cnt_q, cnt_d;
  logic                  valid_q, valid_d;
  logic                  dump_done_q, dump_done_d;

  logic                  ram_we;
  logic [MEM_ADDR-1:0]   ram_waddr;
  logic [MEM_WIDTH-1:0]  ram_wdata;
  logic                  dump_rd_en;

  // State and pointer registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      cnt_q       <= '0;
      valid_q     <= 1'b0;
      dump_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      valid_q     <= valid_d;
      dump_done_q <= dump_done_d;
    end
  end

  // Next-state logic, write-port mux and dump read enable.
  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    cnt_d         = cnt_q;
    valid_d       = valid_q;
    dump_done_d   = 1'b0;
    ram_we        = 1'b0;
    ram_waddr     = ptr_q;
    ram_wdata     = host_wr_data;
    dump_rd_en    = 1'b0;
    host_wr_ready = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        valid_d = 1'b0;
        // start has priority over a simultaneous preload request.
        if (start) begin
          state_d = ST_RUN;
        end else if (host_wr_valid) begin
          state_d = ST_LOAD;
          ptr_d   = load_base;
        end
      end
      ST_LOAD: begin
        host_wr_ready = 1'b1;
        if (host_wr_valid) begin
          ram_we    = 1'b1;
          ram_waddr = ptr_q;
          ram_wdata = host_wr_data;
          ptr_d     = ptr_q + 1'b1;
          if (host_wr_last) state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (core_we) begin
          ram_we    = 1'b1;
          ram_waddr = core_addr;
          ram_wdata = core_wdata;
        end
        if (done) begin
          if (dump_len == '0) begin
            state_d     = ST_IDLE;
            dump_done_d = 1'b1;
          end else begin
            state_d = ST_DUMP;
            ptr_d   = dump_base;
            cnt_d   = dump_len;
            valid_d = 1'b0;
          end
        end
      end
      ST_DUMP: begin
        // With valid low the read port is primed from ptr; valid rises next.
        if (!valid_q) begin
          dump_rd_en = 1'b1;
          valid_d    = 1'b1;
        end else if (host_rd_ready) begin
          ptr_d   = ptr_q + 1'b1;
          cnt_d   = cnt_q - 1'b1;
          valid_d = 1'b0;
          if (cnt_q == {{MEM_ADDR{1'b0}}, 1'b1}) begin
            state_d     = ST_IDLE;
            dump_done_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign host_rd_valid = valid_q;
  assign dump_done     = dump_done_q;
  assign busy          = (state_q != ST_IDLE);
  assign state_dbg     = state_q;

  // A reset edge must not commit a write from an aborted transfer.
  dm_ram #(
    .W (MEM_WIDTH),
    .A (MEM_ADDR)
  ) u_ram (
    .clock     (clock),
    .reset     (reset),
    .we_i      (ram_we & ~reset),
    .waddr_i   (ram_waddr),
    .wdata_i   (ram_wdata),
    .a_addr_i  (core_addr),
    .a_rdata_o (core_rdata),
    .b_en_i    (dump_rd_en),
    .b_addr_i  (ptr_q),
    .b_rdata_o (host_rd_data)
  );

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder.
module tb_data_mem_responder;
  import data_mem_pkg::*;

  logic        clock;
  logic        reset;
  logic [11:0] core_addr;
  logic [11:0] core_wdata;
  logic        core_we;
  logic [11:0] core_rdata;
  logic        start;
  logic        done;
  logic [11:0] load_base;
  logic        host_wr_valid;
  logic [11:0] host_wr_data;
  logic        host_wr_last;
  logic        host_wr_ready;
  logic [11:0] dump_base;
  logic [12:0] dump_len;
  logic        host_rd_valid;
  logic [11:0] host_rd_data;
  logic        host_rd_ready;
  logic        dump_done;
  logic        busy;
  logic [1:0]  state_dbg;

  int checks = 0;
  int passed = 0;
  logic [11:0] exp_q[$];
  logic [11:0] exp_w;

  data_mem_responder #(.MEM_WIDTH(12), .MEM_ADDR(12)) dut (
    .clock         (clock),
    .reset         (reset),
    .core_addr     (core_addr),
    .core_wdata    (core_wdata),
    .core_we       (core_we),
    .core_rdata    (core_rdata),
    .start         (start),
    .done          (done),
    .load_base     (load_base),
    .host_wr_valid (host_wr_valid),
    .host_wr_data  (host_wr_data),
    .host_wr_last  (host_wr_last),
    .host_wr_ready (host_wr_ready),
    .dump_base     (dump_base),
    .dump_len      (dump_len),
    .host_rd_valid (host_rd_valid),
    .host_rd_data  (host_rd_data),
    .host_rd_ready (host_rd_ready),
    .dump_done     (dump_done),
    .busy          (busy),
    .state_dbg     (state_dbg)
  );

  // Clock generation.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one cycle; outputs are sampled and inputs driven 1ns after the edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Preload a burst through the host write stream (starting from IDLE).
  task automatic do_load(input logic [11:0] base, input logic [11:0] w0,
                         input logic [11:0] w1, input logic [11:0] w2,
                         input int n);
    logic [11:0] w [3];
    w[0] = w0; w[1] = w1; w[2] = w2;
    load_base     = base;
    host_wr_valid = 1'b1;
    host_wr_data  = w[0];
    host_wr_last  = 1'b0;
    tick();
    for (int i = 0; i < n; i++) begin
      host_wr_data = w[i];
      host_wr_last = (i == n - 1);
      tick();
    end
    host_wr_valid = 1'b0;
    host_wr_last  = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++; if (state_dbg !== ST_IDLE) $display("FAIL reset_state got=%0d exp=%0d", state_dbg, ST_IDLE); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else passed++;
    checks++; if (host_wr_ready !== 1'b0) $display("FAIL reset_wr_ready got=%b exp=0", host_wr_ready); else passed++;
    checks++; if (host_rd_valid !== 1'b0) $display("FAIL reset_rd_valid got=%b exp=0", host_rd_valid); else passed++;
    checks++; if (dump_done !== 1'b0) $display("FAIL reset_dump_done got=%b exp=0", dump_done); else passed++;
    checks++; if (core_rdata !== 12'h000) $display("FAIL reset_core_rdata got=%h exp=000", core_rdata); else passed++;
    checks++; if (host_rd_data !== 12'h000) $display("FAIL reset_rd_data got=%h exp=000", host_rd_data); else passed++;
    reset = 1'b0;
  endtask

  task automatic test_preload();
    logic [11:0] w [3];
    w[0] = 12'h111; w[1] = 12'h222; w[2] = 12'h333;
    load_base     = 12'h010;
    host_wr_valid = 1'b1;
    host_wr_data  = w[0];
    tick();
    checks++; if (state_dbg !== ST_LOAD) $display("FAIL load_enter got=%0d exp=%0d", state_dbg, ST_LOAD); else passed++;
    checks++; if (host_wr_ready !== 1'b1) $display("FAIL load_ready got=%b exp=1", host_wr_ready); else passed++;
    for (int i = 0; i < 3; i++) begin
      host_wr_data = w[i];
      host_wr_last = (i == 2);
      tick();
    end
    host_wr_valid = 1'b0;
    host_wr_last  = 1'b0;
    checks++; if (state_dbg !== ST_IDLE) $display("FAIL load_exit got=%0d exp=%0d", state_dbg, ST_IDLE); else passed++;
    checks++; if (host_wr_ready !== 1'b0) $display("FAIL load_ready_idle got=%b exp=0", host_wr_ready); else passed++;
    for (int i = 0; i < 3; i++) begin
      core_addr = 12'h010 + 12'(i);
      tick();
      checks++; if (core_rdata !== w[i]) $display("FAIL load_readback[%0d] got=%h exp=%h", i, core_rdata, w[i]); else passed++;
    end
  endtask

  task automatic test_ignored_in_idle();
    do_load(12'h020, 12'h0F0, 12'h000, 12'h000, 1);
    core_addr  = 12'h020;
    core_wdata = 12'h555;
    core_we    = 1'b1;
    done       = 1'b1;
    tick();
    core_we = 1'b0;
    done    = 1'b0;
    checks++; if (state_dbg !== ST_IDLE) $display("FAIL idle_done_ignored got=%0d exp=%0d", state_dbg, ST_IDLE); else passed++;
    tick();
    checks++; if (core_rdata !== 12'h0F0) $display("FAIL idle_write_ignored got=%h exp=0f0", core_rdata); else passed++;
  endtask

  task automatic test_core_rw();
    start = 1'b1;
    host_wr_valid = 1'b1;
    tick();
    start = 1'b0;
    host_wr_valid = 1'b0;
    checks++; if (state_dbg !== ST_RUN) $display("FAIL run_enter got=%0d exp=%0d", state_dbg, ST_RUN); else passed++;
    checks++; if (busy !== 1'b1) $display("FAIL run_busy got=%b exp=1", busy); else passed++;
    core_addr = 12'h011;
    tick();
    checks++; if (core_rdata !== 12'h222) $display("FAIL core_read got=%h exp=222", core_rdata); else passed++;
    core_we    = 1'b1;
    core_wdata = 12'hABC;
    start      = 1'b1;
    host_wr_valid = 1'b1;
    tick();
    core_we = 1'b0;
    start   = 1'b0;
    host_wr_valid = 1'b0;
    checks++; if (core_rdata !== 12'h222) $display("FAIL core_rdw_old got=%h exp=222", core_rdata); else passed++;
    checks++; if (state_dbg !== ST_RUN) $display("FAIL run_ignores_start got=%0d exp=%0d", state_dbg, ST_RUN); else passed++;
    checks++; if (host_wr_ready !== 1'b0) $display("FAIL run_wr_ready got=%b exp=0", host_wr_ready); else passed++;
    tick();
    checks++; if (core_rdata !== 12'hABC) $display("FAIL core_rdw_new got=%h exp=abc", core_rdata); else passed++;
  endtask

  task automatic test_dump_backpressure();
    exp_q = '{12'h111, 12'hABC, 12'h333};
    dump_base     = 12'h010;
    dump_len      = 13'd3;
    host_rd_ready = 1'b0;
    done          = 1'b1;
    tick();
    done = 1'b0;
    checks++; if (state_dbg !== ST_DUMP) $display("FAIL dump_enter got=%0d exp=%0d", state_dbg, ST_DUMP); else passed++;
    checks++; if (host_rd_valid !== 1'b0) $display("FAIL dump_prime got=%b exp=0", host_rd_valid); else passed++;
    tick();
    exp_w = exp_q.pop_front();
    checks++; if (host_rd_valid !== 1'b1 || host_rd_data !== exp_w) $display("FAIL dump_w0 valid=%b data=%h exp=%h", host_rd_valid, host_rd_data, exp_w); else passed++;
    host_rd_ready = 1'b1;
    tick();
    host_rd_ready = 1'b0;
    checks++; if (host_rd_valid !== 1'b0) $display("FAIL dump_gap got=%b exp=0", host_rd_valid); else passed++;
    tick();
    exp_w = exp_q.pop_front();
    for (int i = 0; i < 4; i++) begin
      checks++; if (host_rd_valid !== 1'b1 || host_rd_data !== exp_w || dump_done !== 1'b0) $display("FAIL dump_stall[%0d] valid=%b data=%h done=%b exp=%h", i, host_rd_valid, host_rd_data, dump_done, exp_w); else passed++;
      if (i < 3) tick();
    end
    host_rd_ready = 1'b1;
    tick();
    checks++; if (host_rd_valid !== 1'b0 || dump_done !== 1'b0) $display("FAIL dump_gap2 valid=%b done=%b exp=0/0", host_rd_valid, dump_done); else passed++;
    tick();
    exp_w = exp_q.pop_front();
    checks++; if (host_rd_valid !== 1'b1 || host_rd_data !== exp_w) $display("FAIL dump_w2 valid=%b data=%h exp=%h", host_rd_valid, host_rd_data, exp_w); else passed++;
    tick();
    host_rd_ready = 1'b0;
    checks++; if (dump_done !== 1'b1 || state_dbg !== ST_IDLE || host_rd_valid !== 1'b0) $display("FAIL dump_end done=%b state=%0d valid=%b exp=1/0/0", dump_done, state_dbg, host_rd_valid); else passed++;
    tick();
    checks++; if (dump_done !== 1'b0) $display("FAIL dump_done_pulse got=%b exp=0", dump_done); else passed++;
  endtask

  // Full dump with ready held high, words checked against exp_q.
  task automatic test_dump_stream(input logic [11:0] base, input logic [12:0] len, input string tag);
    start = 1'b1;
    tick();
    start         = 1'b0;
    dump_base     = base;
    dump_len      = len;
    host_rd_ready = 1'b1;
    done          = 1'b1;
    tick();
    done = 1'b0;
    for (int i = 0; i < int'(len); i++) begin
      tick();
      exp_w = exp_q.pop_front();
      checks++; if (host_rd_valid !== 1'b1 || host_rd_data !== exp_w) $display("FAIL %s_word[%0d] valid=%b data=%h exp=%h", tag, i, host_rd_valid, host_rd_data, exp_w); else passed++;
      tick();
    end
    host_rd_ready = 1'b0;
    checks++; if (dump_done !== 1'b1 || busy !== 1'b0) $display("FAIL %s_end done=%b busy=%b exp=1/0", tag, dump_done, busy); else passed++;
  endtask

  task automatic test_boundaries();
    do_load(12'hFFF, 12'h7A1, 12'h7A2, 12'h000, 2);
    core_addr = 12'hFFF;
    tick();
    checks++; if (core_rdata !== 12'h7A1) $display("FAIL wrap_load_fff got=%h exp=7a1", core_rdata); else passed++;
    core_addr = 12'h000;
    tick();
    checks++; if (core_rdata !== 12'h7A2) $display("FAIL wrap_load_000 got=%h exp=7a2", core_rdata); else passed++;
    exp_q = '{12'h7A1, 12'h7A2};
    test_dump_stream(12'hFFF, 13'd2, "wrap_dump");
    start = 1'b1;
    tick();
    start    = 1'b0;
    dump_len = 13'd0;
    done     = 1'b1;
    tick();
    done = 1'b0;
    checks++; if (state_dbg !== ST_IDLE || dump_done !== 1'b1 || host_rd_valid !== 1'b0) $display("FAIL len0 state=%0d done=%b valid=%b exp=0/1/0", state_dbg, dump_done, host_rd_valid); else passed++;
    tick();
    checks++; if (dump_done !== 1'b0) $display("FAIL len0_pulse got=%b exp=0", dump_done); else passed++;
  endtask

  task automatic test_reset_mid_dump();
    start = 1'b1;
    tick();
    start         = 1'b0;
    dump_base     = 12'h010;
    dump_len      = 13'd3;
    host_rd_ready = 1'b1;
    done          = 1'b1;
    tick();
    done = 1'b0;
    tick();
    checks++; if (host_rd_data !== 12'h111) $display("FAIL abort_w0 got=%h exp=111", host_rd_data); else passed++;
    tick();
    host_rd_ready = 1'b0;
    tick();
    checks++; if (host_rd_valid !== 1'b1) $display("FAIL abort_w1_valid got=%b exp=1", host_rd_valid); else passed++;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (host_rd_valid !== 1'b0 || state_dbg !== ST_IDLE || busy !== 1'b0) $display("FAIL abort_reset valid=%b state=%0d busy=%b exp=0/0/0", host_rd_valid, state_dbg, busy); else passed++;
    tick();
    checks++; if (host_rd_valid !== 1'b0 || state_dbg !== ST_IDLE) $display("FAIL abort_stay valid=%b state=%0d exp=0/0", host_rd_valid, state_dbg); else passed++;
    exp_q = '{12'h111, 12'hABC, 12'h333};
    test_dump_stream(12'h010, 13'd3, "redump");
  endtask

  // Test sequence and final report.
  initial begin
    reset = 1'b1; core_addr = '0; core_wdata = '0; core_we = 1'b0;
    start = 1'b0; done = 1'b0; load_base = '0; host_wr_valid = 1'b0;
    host_wr_data = '0; host_wr_last = 1'b0; dump_base = '0; dump_len = '0;
    host_rd_ready = 1'b0;
    test_reset();
    test_preload();
    test_ignored_in_idle();
    test_core_rw();
    test_dump_backpressure();
    test_boundaries();
    test_reset_mid_dump();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter MEM_WIDTH, default 12, data word width in bits.
REQ-002 Parameter MEM_ADDR, default 12, address width in bits; depth SHALL be 2^MEM_ADDR words.
REQ-003 Clocking SHALL use one clock; reset SHALL be synchronous and active-high.
REQ-004 clock  input  1  sole clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 core_addr  input  MEM_ADDR  core data-memory address.
REQ-007 core_wdata  input  MEM_WIDTH  core write data.
REQ-008 core_we  input  1  core write enable.
REQ-009 core_rdata  output  MEM_WIDTH  registered read data to core.
REQ-010 start  input  1  core start request; IDLE->RUN.
REQ-011 done  input  1  core completion; RUN->DUMP.
REQ-012 load_base  input  MEM_ADDR  first address of host preload burst.
REQ-013 host_wr_valid / host_wr_data (MEM_WIDTH) / host_wr_last  input  host preload stream.
REQ-014 host_wr_ready  output  1  preload word accepted when valid&ready.
REQ-015 dump_base  input  MEM_ADDR; dump_len  input  MEM_ADDR+1  result region to stream out.
REQ-016 host_rd_valid / host_rd_data (MEM_WIDTH)  output; host_rd_ready  input  result stream.
REQ-017 dump_done  output  1  one-cycle pulse at dump completion; busy  output  1  state != IDLE.

Function
REQ-018 FSM states SHALL be IDLE, LOAD, RUN, DUMP.
REQ-019 IDLE: start -> RUN; else host_wr_valid -> LOAD with ptr<=load_base (start wins if simultaneous).
REQ-020 LOAD: host_wr_ready=1; each handshake writes mem[ptr], ptr<=ptr+1 mod 2^MEM_ADDR; handshake with host_wr_last -> IDLE.
REQ-021 host_wr_ready SHALL be 0 in every state except LOAD.
REQ-022 core_rdata SHALL equal mem[core_addr] sampled at the previous edge (1-cycle latency) in all states; read-during-write returns old data.
REQ-023 Core writes (core_we=1) SHALL update memory only in RUN; ignored elsewhere.
REQ-024 RUN: done -> DUMP with ptr<=dump_base, cnt<=dump_len; if dump_len==0 -> IDLE with dump_done pulse instead.
REQ-025 DUMP: one prime cycle after entry, then host_rd_valid=1 with host_rd_data=mem[ptr]; data held stable while valid&!ready.
REQ-026 Each DUMP handshake: ptr+1 (wrap), cnt-1; host_rd_valid drops exactly one cycle, then presents next word.
REQ-027 Handshake on final word (cnt==1) -> IDLE; dump_done=1 that cycle+1 only.
REQ-028 start outside IDLE, done outside RUN, host_wr_valid outside IDLE/LOAD SHALL be ignored.
REQ-029 Pointer wrap from 2^MEM_ADDR-1 to 0 SHALL be silent in LOAD and DUMP.

Reset
REQ-030 Reset SHALL force IDLE, ptr=0, cnt=0, core_rdata=0, host_rd_data=0, host_rd_valid=0, host_wr_ready=0, dump_done=0, busy=0.
REQ-031 Reset SHALL NOT clear memory contents; reset mid-LOAD/RUN/DUMP aborts with no further writes.

Structure
REQ-032 Shared package data_mem_pkg SHALL hold FSM state encoding (2 bits) and default MEM_WIDTH/MEM_ADDR constants.
REQ-033 Storage SHALL be sub-module dm_ram: one write port, two synchronous read ports (core, dump).
REQ-034 Write port mux: LOAD selects host (ptr, host_wr_data), RUN selects core; no other writer.

Verification
REQ-035 Preload: load_base=0x010, words 0x111,0x222,0x333 (last on third) -> mem[0x010..0x012] hold them; state IDLE after.
REQ-036 Core read: RUN, core_addr=0x011 -> core_rdata=0x222 one cycle later; write 0xABC to 0x011 while reading -> old 0x222, then 0xABC.
REQ-037 Core write outside RUN: IDLE, core_we=1 to 0x020 data 0x555 -> mem[0x020] unchanged.
REQ-038 Dump with backpressure: dump_base=0x010, dump_len=3, ready low 4 cycles on word 2 -> words 0x111,0xABC,0x333 in order, data stable while stalled, dump_done single pulse.
REQ-039 Boundaries: load_base=0xFFF two words -> mem[0xFFF], mem[0x000]; dump_len=0 -> immediate IDLE with dump_done.
REQ-040 Reset mid-DUMP after one word -> IDLE, host_rd_valid=0 next cycle, memory preserved on re-dump.
